// File: rtl/lock_entry_if.sv
// lock_entry_if
//   Bundles the keypad-side and status-side signals of the lock entry
//   sequencer.
//
//   Modports:
//     master : the environment side. It includes the keypad front end, the
//              stored-code register, and the actuator/LED side.
//     slave  : the lock_entry_fsm side.
//
//   Signals:
//     btn_valid      one-cycle strobe, btn_code holds a new keypress
//     btn_code       pressed button value
//     btn_clear      one-cycle strobe, abort the current entry
//     lock_req       one-cycle strobe, re-lock from UNLOCKED
//     length         stored code length in digits, legal range 1..6
//     current_button stored digit at `index`, returned combinationally
//     index          digit position requested, 0 = first digit
//     unlocked       high while unlocked
//     error          one-cycle pulse on a rejected attempt
//     locked_out     high while in lockout
interface lock_entry_if;
  logic       btn_valid;
  logic [3:0] btn_code;
  logic       btn_clear;
  logic       lock_req;
  logic [2:0] length;
  logic [3:0] current_button;
  logic [2:0] index;
  logic       unlocked;
  logic       error;
  logic       locked_out;

  modport master (
    output btn_valid, btn_code, btn_clear, lock_req, length, current_button,
    input  index, unlocked, error, locked_out
  );

  modport slave (
    input  btn_valid, btn_code, btn_clear, lock_req, length, current_button,
    output index, unlocked, error, locked_out
  );
endinterface

// File: rtl/lock_entry_fsm.sv
// lock_entry_fsm
//   Keypad-entry sequencer for the digital lock.
//   - It steps a digit index through the stored-code register.
//   - It compares each keypress with the returned digit.
//   - It decides unlock or reject.
//   - It enforces a timed lockout after MAX_FAILS consecutive failed attempts.
//   The full code length is always consumed before a verdict, so response
//   timing reveals nothing about which digit was wrong.
//
//   Parameters:
//     MAX_FAILS       consecutive failures that trigger lockout (1..15)
//     LOCKOUT_CYCLES  clk cycles spent in LOCKOUT (>= 2)
//     RELOCK_CYCLES   auto-relock delay in UNLOCKED (>= 2). It is used only
//                     when the macro RELOCK_TIMEOUT_EN is defined.
//
//   Configuration macro:
//     RELOCK_TIMEOUT_EN  If defined, UNLOCKED falls back to IDLE after
//                        RELOCK_CYCLES cycles without lock_req. If not
//                        defined, UNLOCKED is held until lock_req or reset.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous reset, active-low
//     bus  lock_entry_if.slave
//          in : btn_valid, btn_code, btn_clear, lock_req, length,
//               current_button
//          out: index, unlocked, error, locked_out (all registered)
module lock_entry_fsm #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int RELOCK_CYCLES  = 250_000_000
) (
  input  logic         clk,
  input  logic         rst,
  lock_entry_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT} state_t;

  localparam int              LC_W      = $clog2(LOCKOUT_CYCLES);
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]      FAIL_MAX  = 4'(MAX_FAILS);

  if (MAX_FAILS < 1 || MAX_FAILS > 15 || LOCKOUT_CYCLES < 2 || RELOCK_CYCLES < 2)
  begin : g_bad_params
    $error("lock_entry_fsm: parameter out of range");
  end

  state_t          state;
  logic [2:0]      index_q;
  logic            mismatch;
  logic [3:0]      fail_cnt;
  logic [LC_W-1:0] lock_cnt;
  logic            unlocked_q;
  logic            error_q;
  logic            locked_out_q;

`ifdef RELOCK_TIMEOUT_EN
  localparam int              RC_W        = $clog2(RELOCK_CYCLES);
  localparam logic [RC_W-1:0] RELOCK_LAST = RC_W'(RELOCK_CYCLES - 1);
  logic [RC_W-1:0] relock_cnt;
`endif

  // Press decode. It depends on the stored digit returned for the current index.
  logic       len_ok;
  logic       eff_mismatch;
  logic       final_digit;
  logic [3:0] fails_next;

  always_comb begin
    len_ok       = (bus.length != 3'd0) && (bus.length <= 3'd6);
    eff_mismatch = mismatch | (bus.btn_code != bus.current_button);
    // ">=" rather than "==" means a length shrunk mid-entry still ends the
    // attempt on the next press.
    final_digit  = ({1'b0, index_q} + 4'd1) >= {1'b0, bus.length};
    fails_next   = fail_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      index_q      <= 3'd0;
      mismatch     <= 1'b0;
      fail_cnt     <= 4'd0;
      lock_cnt     <= '0;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      locked_out_q <= 1'b0;
`ifdef RELOCK_TIMEOUT_EN
      relock_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking defaults first. A later assignment in the same
      // block overrides the default, which makes error a clean one-cycle pulse.
      error_q <= 1'b0;

      unique case (state)
        IDLE, ENTRY: begin
          if (bus.btn_clear) begin
            // Clear wins over a simultaneous keypress.
            // The failure history is kept.
            state    <= IDLE;
            index_q  <= 3'd0;
            mismatch <= 1'b0;
          end else if (bus.btn_valid) begin
            if (!len_ok || final_digit) begin
              index_q  <= 3'd0;
              mismatch <= 1'b0;
              if (len_ok && !eff_mismatch) begin
                state      <= UNLOCKED;
                unlocked_q <= 1'b1;
                fail_cnt   <= 4'd0;
`ifdef RELOCK_TIMEOUT_EN
                relock_cnt <= '0;
`endif
              end else begin
                error_q <= 1'b1;
                if (fails_next == FAIL_MAX) begin
                  state        <= LOCKOUT;
                  locked_out_q <= 1'b1;
                  fail_cnt     <= 4'd0;
                  lock_cnt     <= '0;
                end else begin
                  state    <= IDLE;
                  fail_cnt <= fails_next;
                end
              end
            end else begin
              state    <= ENTRY;
              index_q  <= index_q + 3'd1;
              mismatch <= eff_mismatch;
            end
          end
        end

        UNLOCKED: begin
          if (bus.lock_req) begin
            state      <= IDLE;
            unlocked_q <= 1'b0;
          end
`ifdef RELOCK_TIMEOUT_EN
          else if (relock_cnt == RELOCK_LAST) begin
            state      <= IDLE;
            unlocked_q <= 1'b0;
          end else begin
            relock_cnt <= relock_cnt + RC_W'(1);
          end
`endif
        end

        LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            state        <= IDLE;
            locked_out_q <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + LC_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.index      = index_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.error      = error_q;
  assign bus.locked_out = locked_out_q;

endmodule

// File: tb/tb_lock_entry_fsm.sv
// tb_lock_entry_fsm
//   Directed bench for lock_entry_fsm.
//   - The stored code is 4-7-2.
//   - MAX_FAILS = 3, LOCKOUT_CYCLES = 20, RELOCK_CYCLES = 10.
//   - Inputs change on the falling edge.
//   - Outputs are sampled on the following falling edge, one rising edge later.
module tb_lock_entry_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lock_entry_if bus ();

  lock_entry_fsm #(
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (20),
    .RELOCK_CYCLES  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stored-code register model. It returns a digit combinationally.
  logic [3:0] code_mem [8];
  assign bus.current_button = code_mem[bus.index];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic       clr;
    logic       req;
    logic [2:0] len;
    logic [5:0] exp;   // {index, unlocked, error, locked_out}
  } vec_t;

  vec_t vecs [34];

  function automatic vec_t mk(input int v, input int code, input int clr, input int req,
                              input int len, input int idx, input int unl, input int err,
                              input int lo);
    vec_t r;
    r.v    = v[0];
    r.code = code[3:0];
    r.clr  = clr[0];
    r.req  = req[0];
    r.len  = len[2:0];
    r.exp  = {idx[2:0], unl[0], err[0], lo[0]};
    return r;
  endfunction

  function automatic logic [5:0] outs();
    return {bus.index, bus.unlocked, bus.error, bus.locked_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs. Return at the next falling edge, ready to sample.
  task automatic drive(input int v, input int code, input int clr, input int req, input int len);
    bus.btn_valid = v[0];
    bus.btn_code  = code[3:0];
    bus.btn_clear = clr[0];
    bus.lock_req  = req[0];
    bus.length    = len[2:0];
    @(negedge clk);
  endtask

  task automatic press(input int code);
    drive(1, code, 0, 0, 3);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3);
  endtask

  initial begin
    int  hi;
    bit  ok;
    code_mem = '{4'd4, 4'd7, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    bus.btn_valid = 1'b0;
    bus.btn_code  = 4'd0;
    bus.btn_clear = 1'b0;
    bus.lock_req  = 1'b0;
    bus.length    = 3'd3;

    // Reset state, both while reset is held and after release.
    #1 check("reset_held", 32'(outs()), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle();
    check("reset_release", 32'(outs()), 32'h0);

    // Fields: v, code, clr, req, len | idx, unl, err, lo.
    vecs[0]  = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[1]  = mk(1, 7, 0, 0, 3,  2, 0, 0, 0);
    vecs[2]  = mk(1, 2, 0, 0, 3,  0, 1, 0, 0);  // correct code unlocks
    vecs[3]  = mk(0, 0, 0, 0, 3,  0, 1, 0, 0);
    vecs[4]  = mk(1, 4, 1, 0, 3,  0, 1, 0, 0);  // keys ignored while unlocked
    vecs[5]  = mk(0, 0, 0, 1, 3,  0, 0, 0, 0);  // lock_req relocks
    vecs[6]  = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 3,  2, 0, 0, 0);  // wrong digit, no early reject
    vecs[8]  = mk(1, 2, 0, 0, 3,  0, 0, 1, 0);  // reject (fails = 1)
    vecs[9]  = mk(0, 0, 0, 0, 3,  0, 0, 0, 0);  // error is a single pulse
    vecs[10] = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[11] = mk(1, 7, 0, 0, 3,  2, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 3,  0, 0, 0, 0);  // clear aborts, no error
    vecs[13] = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[14] = mk(1, 7, 0, 0, 3,  2, 0, 0, 0);
    vecs[15] = mk(1, 2, 0, 0, 3,  0, 1, 0, 0);  // unlock (fails -> 0)
    vecs[16] = mk(0, 0, 0, 1, 3,  0, 0, 0, 0);
    vecs[17] = mk(1, 5, 0, 0, 0,  0, 0, 1, 0);  // length 0 rejects (fails = 1)
    vecs[18] = mk(1, 4, 0, 0, 7,  0, 0, 1, 0);  // length 7 rejects (fails = 2)
    vecs[19] = mk(1, 4, 0, 0, 1,  0, 1, 0, 0);  // length 1 unlocks at once
    vecs[20] = mk(0, 0, 0, 1, 3,  0, 0, 0, 0);
    vecs[21] = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[22] = mk(1, 7, 1, 0, 3,  0, 0, 0, 0);  // clear beats valid
    vecs[23] = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[24] = mk(1, 9, 0, 0, 1,  0, 0, 1, 0);  // shrunk length ends entry (fails = 1)
    vecs[25] = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[26] = mk(1, 7, 0, 0, 3,  2, 0, 0, 0);
    vecs[27] = mk(1, 2, 0, 0, 3,  0, 1, 0, 0);  // mismatch flag was cleared
    vecs[28] = mk(0, 0, 0, 1, 3,  0, 0, 0, 0);
    vecs[29] = mk(1, 4, 0, 0, 3,  1, 0, 0, 0);
    vecs[30] = mk(0, 0, 0, 1, 3,  1, 0, 0, 0);  // lock_req ignored in entry
    vecs[31] = mk(1, 7, 0, 0, 3,  2, 0, 0, 0);
    vecs[32] = mk(1, 2, 0, 0, 3,  0, 1, 0, 0);
    vecs[33] = mk(0, 0, 0, 1, 3,  0, 0, 0, 0);

    for (int i = 0; i < 34; i++) begin
      drive(int'(vecs[i].v), int'(vecs[i].code), int'(vecs[i].clr),
            int'(vecs[i].req), int'(vecs[i].len));
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Lockout after three consecutive failures. The fail count is 0 here.
    press(9);
    check("lo_no_early_reject", 32'(bus.index), 32'd1);
    press(7);
    press(2);
    check("lo_fail1", 32'(outs()), 32'b000_0_1_0);
    idle();
    press(4); press(7); press(3);
    check("lo_fail2", 32'(outs()), 32'b000_0_1_0);
    press(0); press(0); press(0);
    check("lo_fail3_enter", 32'(outs()), 32'b000_0_1_1);
    hi = 1;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      press((k % 3 == 0) ? 4 : (k % 3 == 1) ? 7 : 2);
      if (bus.unlocked || bus.index != 3'd0 || bus.error) ok = 1'b0;
      if (bus.locked_out) hi++;
    end
    check("lo_inputs_ignored", 32'(ok), 32'd1);
    for (int k = 0; k < 60; k++) begin
      idle();
      if (bus.locked_out) hi++;
      else break;
    end
    check("lo_duration", 32'(hi), 32'd20);
    press(4); press(7); press(2);
    check("lo_then_unlock", 32'(outs()), 32'b000_1_0_0);
    drive(0, 0, 0, 1, 3);

    // Auto-relock timeout, or an indefinite hold until lock_req.
    press(4); press(7); press(2);
    check("relock_unlock", 32'(bus.unlocked), 32'd1);
`ifdef RELOCK_TIMEOUT_EN
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (bus.unlocked) hi++;
      else break;
    end
    check("relock_duration", 32'(hi), 32'd10);
`else
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      idle();
      if (!bus.unlocked) ok = 1'b0;
    end
    check("hold_100_cycles", 32'(ok), 32'd1);
    drive(0, 0, 0, 1, 3);
    check("hold_lock_req", 32'(bus.unlocked), 32'd0);
`endif

    // Reset mid-entry clears the index immediately and loses the fail count.
    idle();
    press(1); press(1); press(1);
    press(1); press(1); press(1);
    check("rst_mid_fail2", 32'(outs()), 32'b000_0_1_0);
    press(4);
    bus.btn_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check("rst_mid_async", 32'(outs()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    press(1); press(1); press(1);
    check("rst_mid_count_lost", 32'(outs()), 32'b000_0_1_0);
    press(4); press(7); press(2);
    check("rst_mid_unlock", 32'(outs()), 32'b000_1_0_0);
    drive(0, 0, 0, 1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
